// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester code-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DBG
    } owner_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one that did not win last.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       req_cpu,
    input  logic       req_dbg,
    input  owner_e     last_winner,
    output logic [1:0] grant
);

    // grant[0] = CPU, grant[1] = debug loader
    always_comb begin
        grant = 2'b00;
        if (req_cpu && req_dbg) begin
            grant = (last_winner == OWN_CPU) ? 2'b10 : 2'b01;
        end else if (req_cpu) begin
            grant = 2'b01;
        end else if (req_dbg) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates CPU fetches and debug-loader accesses onto one single-port sync RAM.
// Define MEM_ARB_BOUNDS_EN to add out-of-range detection (addr_err) instead of address wrap.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MEM_DEPTH = 1024,
    localparam int unsigned MA_W     = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_BOUNDS_EN
    ,
    output logic              addr_err
`endif
);

    state_e            state_q, state_d;
    owner_e            last_q, last_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic [DATA_W-1:0] cpu_hold_q, dbg_hold_q;
    logic [DATA_W-1:0] rd_value;
    logic [1:0]        grant;
    logic              lock_hold;
    logic              gnt_any;
    logic              oob;
    logic [ADDR_W-1:0] sel_addr;

    // While locked and the loader still asserts lock, the CPU is masked out entirely.
    // Requests are also gated by rst_n so grants drop the instant reset asserts.
    assign lock_hold = (state_q == LOCKED) && dbg_lock;

    mem_arb_rr u_rr (
        .req_cpu     (cpu_req && !lock_hold && rst_n),
        .req_dbg     (dbg_req && rst_n),
        .last_winner (last_q),
        .grant       (grant)
    );

    assign cpu_gnt  = grant[0];
    assign dbg_gnt  = grant[1];
    assign gnt_any  = grant[0] | grant[1];
    assign sel_addr = grant[1] ? dbg_addr : cpu_addr;

`ifdef MEM_ARB_BOUNDS_EN
    logic rd_oob_q;

    assign oob      = (sel_addr >> MA_W) != '0;
    assign addr_err = gnt_any && oob;
    assign rd_value = rd_oob_q ? '0 : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_oob_q <= 1'b0;
        end else begin
            rd_oob_q <= gnt_any && oob;
        end
    end
`else
    logic unused_addr;

    // Upper address bits are discarded: accesses wrap modulo MEM_DEPTH.
    assign oob         = 1'b0;
    assign rd_value    = mem_rdata;
    assign unused_addr = ^sel_addr[ADDR_W-1:MA_W];
`endif

    assign mem_en    = gnt_any && !oob;
    assign mem_we    = mem_en && grant[1] && dbg_we;
    assign mem_addr  = sel_addr[MA_W-1:0];
    assign mem_wdata = dbg_wdata;

    assign cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign dbg_rvalid = (rd_owner_q == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? rd_value : cpu_hold_q;
    assign dbg_rdata  = dbg_rvalid ? rd_value : dbg_hold_q;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        rd_owner_d = OWN_NONE;
        if (grant[0]) begin
            last_d     = OWN_CPU;
            rd_owner_d = OWN_CPU;
        end
        if (grant[1]) begin
            last_d = OWN_DBG;
            if (!dbg_we) begin
                rd_owner_d = OWN_DBG;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (grant[1] && dbg_lock) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (!dbg_lock) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= OWN_DBG;
            rd_owner_q <= OWN_NONE;
            cpu_hold_q <= '0;
            dbg_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rd_owner_q <= rd_owner_d;
            if (cpu_rvalid) begin
                cpu_hold_q <= rd_value;
            end
            if (dbg_rvalid) begin
                dbg_hold_q <= rd_value;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Randomized self-checking bench for mem_arb against a rule-level reference model.
module tb_mem_arb;
    localparam int MEM_DEPTH = 1024;
    localparam int MA_W      = 10;
`ifdef MEM_ARB_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [15:0] cpu_addr = '0, dbg_addr = '0;
    logic [7:0]  dbg_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we;
    logic [7:0]  cpu_rdata, dbg_rdata, mem_wdata;
    logic [7:0]  mem_rdata;
    logic [MA_W-1:0] mem_addr;
`ifdef MEM_ARB_BOUNDS_EN
    logic        addr_err;
`endif

    mem_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_lock   (dbg_lock),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_BOUNDS_EN
        ,
        .addr_err   (addr_err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency.
    logic [7:0] ram [MEM_DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: who owns lock, who won last, what read is in flight.
    bit         m_locked;
    int         m_last;      // 0 = cpu, 1 = dbg
    int         m_pend;      // -1 none, 0 cpu, 1 dbg
    logic [7:0] m_pend_data, m_cpu_last, m_dbg_last;
    logic [7:0] shadow [MEM_DEPTH];
    logic [32:0] obs, exp_v;

    task automatic model_reset();
        m_locked = 1'b0;
        m_last = 1;
        m_pend = -1;
        m_pend_data = 8'h00;
        m_cpu_last = 8'h00;
        m_dbg_last = 8'h00;
    endtask

    function automatic logic [32:0] get_obs();
        logic e;
`ifdef MEM_ARB_BOUNDS_EN
        e = addr_err;
`else
        e = 1'b0;
`endif
        return {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata,
                mem_en, mem_en & mem_we, mem_en ? mem_addr : {MA_W{1'b0}}, e};
    endfunction

    // Drive one cycle's inputs, sample the DUT and compute what the rules predict.
    task automatic run_cycle(input logic cr, input logic [15:0] ca, input logic dr,
                             input logic dwe, input logic [15:0] da, input logic [7:0] dwd,
                             input logic dl);
        int win;
        bit cpu_ok, oob, en, crv, drv;
        logic [15:0] a;
        int idx;
        @(negedge clk);
        cpu_req = cr; cpu_addr = ca; dbg_req = dr; dbg_we = dwe;
        dbg_addr = da; dbg_wdata = dwd; dbg_lock = dl;
        #1;
        obs = get_obs();
        crv = (m_pend == 0);
        drv = (m_pend == 1);
        if (crv) m_cpu_last = m_pend_data;
        if (drv) m_dbg_last = m_pend_data;
        cpu_ok = cr && !(m_locked && dl);
        if (cpu_ok && dr) win = (m_last == 1) ? 0 : 1;
        else if (cpu_ok)  win = 0;
        else if (dr)      win = 1;
        else              win = -1;
        a = (win == 1) ? da : ca;
        idx = int'(a) % MEM_DEPTH;
        oob = BOUNDS && (int'(a) >= MEM_DEPTH);
        en = (win >= 0) && !oob;
        exp_v = {win == 0, win == 1, crv, drv, m_cpu_last, m_dbg_last, en,
                 en && win == 1 && dwe, en ? MA_W'(idx) : {MA_W{1'b0}}, (win >= 0) && oob};
        if (win == 0 || (win == 1 && !dwe)) begin
            m_pend = win;
            m_pend_data = oob ? 8'h00 : shadow[idx];
        end else begin
            m_pend = -1;
        end
        if (en && win == 1 && dwe) shadow[idx] = dwd;
        if (win >= 0) m_last = win;
        m_locked = (win == 1 && dl) || (m_locked && dl);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        cpu_req = 0; dbg_req = 0; dbg_we = 0; dbg_lock = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic fill_mem();
        for (int i = 0; i < MEM_DEPTH; i++) begin
            run_cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'(i), 8'($urandom), 1'b0);
        end
        run_cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (get_obs() !== 33'h0) begin
            n_fails++;
            $display("FAIL reset_state: got %h expected %h", get_obs(), 33'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        fill_mem();
    endtask

    task automatic test_cpu_read();
        reset_dut();
        run_cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 8'hA9, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL cpu_read_wr: got %h expected %h", obs, exp_v); end
        run_cycle(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        n_checks++;
        if (obs !== exp_v || cpu_gnt !== 1'b1) begin
            n_fails++; $display("FAIL cpu_read_gnt: got %h expected %h", obs, exp_v);
        end
        run_cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        n_checks++;
        if (obs !== exp_v || cpu_rdata !== 8'hA9 || cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0) begin
            n_fails++; $display("FAIL cpu_read_data: got %h rdata %h expected %h rdata a9", obs, cpu_rdata, exp_v);
        end
    endtask

    task automatic test_tie();
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            run_cycle(i < 4, 16'($urandom_range(0, 1023)), i < 4, 1'b0,
                      16'($urandom_range(0, 1023)), 8'h0, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin n_fails++; $display("FAIL tie_c%0d: got %h expected %h", i, obs, exp_v); end
            if (i < 4) begin
                n_checks++;
                if (cpu_gnt !== (i % 2 == 0) || dbg_gnt !== (i % 2 == 1)) begin
                    n_fails++; $display("FAIL tie_order_c%0d: got cpu %b dbg %b", i, cpu_gnt, dbg_gnt);
                end
            end
        end
    endtask

    task automatic test_lock();
        reset_dut();
        run_cycle(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL lock_pre: got %h expected %h", obs, exp_v); end
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, 16'h0020, 1'b1, 1'b1, (i == 0) ? 16'h0020 : 16'(16'h0030 + i),
                      (i == 0) ? 8'h55 : 8'($urandom), 1'b1);
            n_checks++;
            if (obs !== exp_v || cpu_gnt !== 1'b0 || dbg_gnt !== 1'b1) begin
                n_fails++; $display("FAIL lock_w%0d: got %h cpu_gnt %b expected %h cpu_gnt 0", i, obs, cpu_gnt, exp_v);
            end
        end
        run_cycle(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        n_checks++;
        if (obs !== exp_v || cpu_gnt !== 1'b1) begin
            n_fails++; $display("FAIL lock_drop: got %h cpu_gnt %b expected %h cpu_gnt 1", obs, cpu_gnt, exp_v);
        end
        run_cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        n_checks++;
        if (obs !== exp_v || cpu_rdata !== 8'h55) begin
            n_fails++; $display("FAIL lock_readback: got %h rdata %h expected rdata 55", obs, cpu_rdata);
        end
    endtask

    task automatic test_oob();
        reset_dut();
        run_cycle(1'b1, 16'h0400, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        n_checks++;
`ifdef MEM_ARB_BOUNDS_EN
        if (obs !== exp_v || addr_err !== 1'b1 || mem_en !== 1'b0) begin
            n_fails++; $display("FAIL oob_grant: got %h err %b en %b expected err 1 en 0", obs, addr_err, mem_en);
        end
`else
        if (obs !== exp_v || mem_addr !== 10'd0 || mem_en !== 1'b1) begin
            n_fails++; $display("FAIL oob_wrap: got %h addr %h expected addr 0", obs, mem_addr);
        end
`endif
        run_cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        n_checks++;
        if (obs !== exp_v || cpu_rdata !== (BOUNDS ? 8'h00 : shadow[0])) begin
            n_fails++; $display("FAIL oob_data: got %h rdata %h expected %h", obs, cpu_rdata, exp_v);
        end
    endtask

    task automatic test_reset_mid_read();
        reset_dut();
        run_cycle(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL rst_mid_gnt: got %h expected %h", obs, exp_v); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (get_obs() !== 33'h0) begin
            n_fails++; $display("FAIL rst_mid_immediate: got %h expected 0", get_obs());
        end
        cpu_req = 0; dbg_req = 0; dbg_lock = 0; dbg_we = 0;
        @(posedge clk);
        #1;
        n_checks++;
        if (get_obs() !== 33'h0) begin
            n_fails++; $display("FAIL rst_mid_held: got %h expected 0", get_obs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_cycle(1'b1, 16'h0005, 1'b1, 1'b0, 16'h0006, 8'h0, 1'b0);
        n_checks++;
        if (obs !== exp_v || cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0) begin
            n_fails++; $display("FAIL rst_mid_release: got %h gnt %b rv %b expected gnt 1 rv 0", obs, cpu_gnt, cpu_rvalid);
        end
    endtask

    task automatic test_random();
        logic cr, dr, dwe, dl;
        logic [15:0] ca, da;
        logic [7:0] dwd;
        cr = 0; dr = 0; dwe = 0; dl = 0; ca = 0; da = 0; dwd = 0;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            if (!cr && $urandom_range(0, 2) != 0) begin
                cr = 1'b1;
                ca = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 2047))
                                                 : 16'($urandom_range(0, 15));
            end
            if (!dr && $urandom_range(0, 2) != 0) begin
                dr = 1'b1;
                dwe = 1'($urandom);
                dwd = 8'($urandom);
                da = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 2047))
                                                 : 16'($urandom_range(0, 15));
            end
            dl = dr && ($urandom_range(0, 3) == 0);
            run_cycle(cr, ca, dr, dwe, da, dwd, dl);
            n_checks++;
            if (obs !== exp_v) begin n_fails++; $display("FAIL random_c%0d: got %h expected %h", i, obs, exp_v); end
            if (exp_v[32]) cr = 1'b0;
            if (exp_v[31]) dr = 1'b0;
        end
        run_cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        n_checks++;
        if (obs !== exp_v) begin n_fails++; $display("FAIL random_tail: got %h expected %h", obs, exp_v); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cpu_read();
        test_tie();
        test_lock();
        test_oob();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
